fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the pipelined MIPS core. It owns the architectural PC register and sequences requests to the instruction memory through a request/grant/response handshake.
- It hands fetched words to the decode stage with a valid/ready handshake.
- It accepts redirects (taken branch, j/jal, jr) from the next-PC logic and squashes wrong-path fetches, including a response that is still outstanding.

---
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : instruction-fetch controller with PC, imem handshake,
//                   decode valid/ready handoff and redirect squashing.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_4,
  output logic        id_exc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_exc_q, buf_exc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pc_aligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      buf_exc_q   <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_exc_q   <= buf_exc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc_aligned = (pc_q[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_exc_d   = buf_exc_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redir_valid) begin
          pc_d = redir_pc;
          // A granted request cannot be recalled; its response must be drained.
          if (pc_aligned && imem_gnt) state_d = DROP;
        end else if (!pc_aligned) begin
          buf_instr_d = 32'd0;
          buf_pc_d    = pc_q;
          buf_exc_d   = 1'b1;
          state_d     = HOLD;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid && !redir_valid) begin
          buf_instr_d = imem_rdata;
          buf_pc_d    = pc_q;
          buf_exc_d   = 1'b0;
          state_d     = HOLD;
        end else if (redir_valid) begin
          pc_d    = redir_pc;
          state_d = imem_rvalid ? REQ : DROP;
        end
      end
      DROP: begin
        if (redir_valid) pc_d = redir_pc;
        if (imem_rvalid) state_d = REQ;
      end
      HOLD: begin
        if (redir_valid) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (id_ready) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = (state_q == REQ) && pc_aligned;
  assign imem_addr = pc_q;
  // Redirect squashes the held slot combinationally in the same cycle.
  assign id_valid  = (state_q == HOLD) && !redir_valid;
  assign id_instr  = buf_instr_q;
  assign id_pc     = buf_pc_q;
  assign id_pc_4   = buf_pc_q + 32'd4;
  assign id_exc    = buf_exc_q;
  assign fetch_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, reset
// corner sequence, and randomized traffic against a transaction-level model.
`default_nettype none

module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_4;
  logic        id_exc;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_4(id_pc_4), .id_exc(id_exc), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] rp;
    logic        g;
    logic        rv;
    logic [31:0] data;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_exc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[40];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic [31:0] rp, input logic g,
                              input logic rv, input logic [31:0] data, input logic rdy,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] instr, input logic [31:0] pc,
                              input logic exc, input logic [31:0] cnt);
    vec_t v;
    v.rd = rd; v.rp = rp; v.g = g; v.rv = rv; v.data = data; v.rdy = rdy;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_instr = instr;
    v.e_pc = pc; v.e_exc = exc; v.e_cnt = cnt;
    return v;
  endfunction

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_idle();
    redir_valid = 1'b0; redir_pc = 32'd0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b1;
  endtask

  localparam logic [31:0] D0 = 32'h3c01_1234, D1 = 32'h2002_0001, D2 = 32'h8c43_0004;
  localparam logic [31:0] D3 = 32'h0062_2020, D4 = 32'h1000_0003, D5 = 32'h2108_ffff;
  localparam logic [31:0] JK = 32'hdead_beef;

  // Random-phase model state
  logic [31:0] mpc, mcnt, raddr;
  logic        outst;
  int          dly, naccept;
  int          r;

  initial begin
    // rd, rp, g, rv, data, rdy | req, addr, vld, instr, pc, exc, cnt
    tbl[0]  = mk(0, 0, 0, 0, 0,  1, 0, 32'h3000, 0, 0,  0,        0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0,  1, 1, 32'h3000, 0, 0,  0,        0, 0);
    tbl[2]  = mk(0, 0, 0, 1, D0, 1, 0, 32'h3000, 0, 0,  0,        0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,  1, 0, 32'h3000, 1, D0, 32'h3000, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0,  1, 1, 32'h3004, 0, D0, 32'h3000, 0, 1);
    tbl[5]  = mk(0, 0, 0, 1, D1, 1, 0, 32'h3004, 0, D0, 32'h3000, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0,  1, 0, 32'h3004, 1, D1, 32'h3004, 0, 1);
    tbl[7]  = mk(0, 0, 1, 0, 0,  1, 1, 32'h3008, 0, D1, 32'h3004, 0, 2);
    tbl[8]  = mk(0, 0, 0, 1, D2, 1, 0, 32'h3008, 0, D1, 32'h3004, 0, 2);
    for (int i = 9; i < 14; i++)
      tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 32'h3008, 1, D2, 32'h3008, 0, 2);
    tbl[14] = mk(0, 0, 0, 0, 0,  1, 0, 32'h3008, 1, D2, 32'h3008, 0, 2);
    tbl[15] = mk(0, 0, 1, 0, 0,  1, 1, 32'h300c, 0, D2, 32'h3008, 0, 3);
    tbl[16] = mk(0, 0, 0, 1, D3, 1, 0, 32'h300c, 0, D2, 32'h3008, 0, 3);
    tbl[17] = mk(0, 0, 0, 0, 0,  1, 0, 32'h300c, 1, D3, 32'h300c, 0, 3);
    tbl[18] = mk(0, 0, 1, 0, 0,  1, 1, 32'h3010, 0, D3, 32'h300c, 0, 4);
    tbl[19] = mk(1, 32'h3100, 0, 0, 0, 1, 0, 32'h3010, 0, D3, 32'h300c, 0, 4);
    tbl[20] = mk(0, 0, 0, 0, 0,  1, 0, 32'h3100, 0, D3, 32'h300c, 0, 4);
    tbl[21] = mk(0, 0, 0, 1, JK, 1, 0, 32'h3100, 0, D3, 32'h300c, 0, 4);
    tbl[22] = mk(0, 0, 1, 0, 0,  1, 1, 32'h3100, 0, D3, 32'h300c, 0, 4);
    tbl[23] = mk(0, 0, 0, 1, D4, 1, 0, 32'h3100, 0, D3, 32'h300c, 0, 4);
    tbl[24] = mk(1, 32'h3200, 0, 0, 0, 1, 0, 32'h3100, 0, D4, 32'h3100, 0, 4);
    tbl[25] = mk(1, 32'h3202, 0, 0, 0, 1, 1, 32'h3200, 0, D4, 32'h3100, 0, 4);
    tbl[26] = mk(0, 0, 0, 0, 0,  1, 0, 32'h3202, 0, D4, 32'h3100, 0, 4);
    tbl[27] = mk(0, 0, 0, 0, 0,  1, 0, 32'h3202, 1, 0,  32'h3202, 1, 4);
    tbl[28] = mk(0, 0, 0, 0, 0,  1, 0, 32'h3206, 0, 0,  32'h3202, 1, 5);
    tbl[29] = mk(0, 0, 0, 0, 0,  0, 0, 32'h3206, 1, 0,  32'h3206, 1, 5);
    tbl[30] = mk(1, 32'h3300, 0, 0, 0, 1, 0, 32'h3206, 0, 0, 32'h3206, 1, 5);
    tbl[31] = mk(0, 0, 1, 0, 0,  1, 1, 32'h3300, 0, 0,  32'h3206, 1, 5);
    tbl[32] = mk(1, 32'h3400, 0, 1, JK, 1, 0, 32'h3300, 0, 0, 32'h3206, 1, 5);
    tbl[33] = mk(1, 32'h3500, 1, 0, 0,  1, 1, 32'h3400, 0, 0, 32'h3206, 1, 5);
    tbl[34] = mk(1, 32'h3600, 0, 0, 0,  1, 0, 32'h3500, 0, 0, 32'h3206, 1, 5);
    tbl[35] = mk(1, 32'h3700, 0, 1, JK, 1, 0, 32'h3600, 0, 0, 32'h3206, 1, 5);
    tbl[36] = mk(0, 0, 1, 0, 0,  1, 1, 32'h3700, 0, 0,  32'h3206, 1, 5);
    tbl[37] = mk(0, 0, 0, 1, D5, 1, 0, 32'h3700, 0, 0,  32'h3206, 1, 5);
    tbl[38] = mk(0, 0, 0, 0, 0,  1, 0, 32'h3700, 1, D5, 32'h3700, 0, 5);
    tbl[39] = mk(0, 0, 0, 0, 0,  1, 1, 32'h3704, 0, D5, 32'h3700, 0, 6);

    reset = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(imem_req),  32'd0);
    chk("rst_valid", 32'(id_valid),  32'd0);
    chk("rst_exc",   32'(id_exc),    32'd0);
    chk("rst_instr", id_instr,       32'd0);
    chk("rst_cnt",   fetch_cnt,      32'd0);

    // Directed vector table
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      reset       = 1'b1;
      redir_valid = tbl[i].rd;  redir_pc   = tbl[i].rp;
      imem_gnt    = tbl[i].g;   imem_rvalid = tbl[i].rv;
      imem_rdata  = tbl[i].data; id_ready  = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d_req", i),   32'(imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_pcreg", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), 32'(id_valid), 32'(tbl[i].e_vld));
      chk($sformatf("row%0d_instr", i), id_instr, tbl[i].e_instr);
      chk($sformatf("row%0d_pc", i),    id_pc, tbl[i].e_pc);
      chk($sformatf("row%0d_pc4", i),   id_pc_4, tbl[i].e_pc + 32'd4);
      chk($sformatf("row%0d_exc", i),   32'(id_exc), 32'(tbl[i].e_exc));
      chk($sformatf("row%0d_cnt", i),   fetch_cnt, tbl[i].e_cnt);
    end

    // Reset asserted mid-WAIT, then a stray response after release
    @(posedge clk); #1;
    drive_idle(); imem_gnt = 1'b1;
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    chk("wait_req", 32'(imem_req), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_req",   32'(imem_req), 32'd0);
    chk("async_rst_addr",  imem_addr,     32'h3000);
    chk("async_rst_valid", 32'(id_valid), 32'd0);
    chk("async_rst_pc",    id_pc,         32'd0);
    chk("async_rst_cnt",   fetch_cnt,     32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; imem_rvalid = 1'b1; imem_rdata = JK;
    @(negedge clk);
    chk("stray_req",   32'(imem_req), 32'd0);
    chk("stray_valid", 32'(id_valid), 32'd0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    chk("restart_req",  32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr,     32'h3000);
    chk("restart_valid", 32'(id_valid), 32'd0);
    @(posedge clk); #1;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = D0;
    @(negedge clk);
    chk("restart_wait_valid", 32'(id_valid), 32'd0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    chk("restart_valid2", 32'(id_valid), 32'd1);
    chk("restart_instr",  id_instr,      D0);
    chk("restart_pc",     id_pc,         32'h3000);
    chk("restart_cnt",    fetch_cnt,     32'd0);

    // Randomized traffic against a transaction-level model
    @(posedge clk); #1;
    reset = 1'b0; drive_idle();
    repeat (2) @(posedge clk);
    mpc = 32'h3000; mcnt = 32'd0; outst = 1'b0; dly = 0; naccept = 0; raddr = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      imem_rvalid = 1'b0; imem_rdata = 32'd0;
      if (outst) begin
        dly--;
        if (dly == 0) begin
          imem_rvalid = 1'b1; imem_rdata = memf(raddr); outst = 1'b0;
        end
      end
      imem_gnt    = imem_req && !outst && ($urandom_range(0, 2) != 0);
      redir_valid = (cyc >= 2) && ($urandom_range(0, 7) == 0);
      r = int'($urandom_range(0, 15));
      if (r == 0)      redir_pc = 32'hFFFF_FFF8;
      else if (r < 3)  redir_pc = 32'h3000 + ($urandom_range(0, 255) << 2) + $urandom_range(1, 3);
      else             redir_pc = 32'h3000 + ($urandom_range(0, 255) << 2);
      id_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (imem_req) begin
        chk("rnd_addr", imem_addr, mpc);
        chk("rnd_single_outstanding", 32'(outst), 32'd0);
      end
      if (redir_valid) chk("rnd_squash", 32'(id_valid), 32'd0);
      chk("rnd_cnt", fetch_cnt, mcnt);
      if (id_valid && id_ready) begin
        chk("rnd_pc",    id_pc,        mpc);
        chk("rnd_pc4",   id_pc_4,      mpc + 32'd4);
        chk("rnd_exc",   32'(id_exc),  32'(mpc[1:0] != 2'b00));
        chk("rnd_instr", id_instr,     (mpc[1:0] != 2'b00) ? 32'd0 : memf(mpc));
        mpc  = mpc + 32'd4;
        mcnt = mcnt + 32'd1;
        naccept++;
      end
      if (redir_valid) mpc = redir_pc;
      if (imem_gnt && imem_req) begin
        outst = 1'b1; raddr = imem_addr; dly = int'($urandom_range(1, 3));
      end
    end
    chk("rnd_accepts_seen", 32'(naccept >= 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
